// File: rtl/time_redundant_lock_arbiter_pkg.sv
// Shared types and helpers for the time-redundant lock arbiter.
//
// Contents:
//   arb_state_e - arbiter state (idle round-robin or locked on one input)
//   next_idx()  - modulo-n increment of an input index
package time_redundant_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index after idx, wrapping to 0 at n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/time_redundant_lock_arbiter_pick.sv
// rr_lock_pick: combinational round-robin first-valid search.
//
// Ports:
//   valid_i [NumIn] - request vector
//   ptr_i   [IdxW]  - search start index (highest priority)
//   sel_o   [IdxW]  - first requesting index at or after ptr_i, wrapping;
//                     equals ptr_i when nothing requests
//   any_o           - at least one request is present
module rr_lock_pick #(
  parameter int unsigned NumIn = 3,
  parameter int unsigned IdxW  = 2
) (
  input  logic [NumIn-1:0] valid_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  sel_o,
  output logic             any_o
);

  // Two descending passes: the lowest wrapped requester (below ptr) is taken
  // first, then overridden by the lowest requester at or above ptr, which
  // yields the first hit in rotated order without variable-width modulo.
  always_comb begin
    sel_o = ptr_i;
    any_o = 1'b0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (valid_i[i] && (IdxW'(i) < ptr_i)) begin
        sel_o = IdxW'(i);
        any_o = 1'b1;
      end
    end
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (valid_i[i] && (IdxW'(i) >= ptr_i)) begin
        sel_o = IdxW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_redundant_lock_arbiter.sv
// time_redundant_lock_arbiter: round-robin merge of NumIn operation-group
// outputs that holds the grant on one input until all Redundancy copies of an
// item have been handed over. A lock ends on the last copy, on the watchdog
// (LockTimeout cycles without a handshake), on flush, or on reset. With the
// macro REDUNDANCY_CELLS_ARB_ID_CHECK_EN defined, an ID change on the locked
// input also ends the lock and the new item is re-arbitrated first.
//
// Ports:
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   flush_i              - return to idle, pointer to 0
//   valid_i/ready_o      - per-input handshake
//   data_i/id_i          - per-input payload and redundancy ID
//   valid_o/ready_i      - merged output handshake
//   data_o/id_o/idx_o    - forwarded payload, ID and source index
//   locked_o             - arbiter holds a lock
//   timeout_o            - one-cycle pulse when the watchdog releases a lock
module time_redundant_lock_arbiter
  import time_redundant_arb_pkg::*;
#(
  parameter int unsigned NumIn       = 3,
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned IDSize      = 5,
  parameter int unsigned Redundancy  = 3,
  parameter int unsigned LockTimeout = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic [NumIn-1:0]                      valid_i,
  output logic [NumIn-1:0]                      ready_o,
  input  logic [NumIn-1:0][DataWidth-1:0]       data_i,
  input  logic [NumIn-1:0][IDSize-1:0]          id_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [DataWidth-1:0]                  data_o,
  output logic [IDSize-1:0]                     id_o,
  output logic [((NumIn > 1) ? $clog2(NumIn) : 1)-1:0] idx_o,
  output logic                                  locked_o,
  output logic                                  timeout_o
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned CntW = $clog2(Redundancy) + 1;
  localparam int unsigned TmrW = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(Redundancy - 1);
  localparam logic [TmrW-1:0] TmrLast = (LockTimeout > 0) ? TmrW'(LockTimeout - 1) : '0;

  arb_state_e      state_q;
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [CntW-1:0] cnt_q;
  logic [TmrW-1:0] tmr_q;

  logic [IdxW-1:0] pick_sel;
  logic            pick_any;
  logic [IdxW-1:0] cur_idx;
  logic            cur_valid;
  logic            locked;
  logic            id_mis;
  logic            hs;
  logic            to_hit;

  rr_lock_pick #(
    .NumIn (NumIn),
    .IdxW  (IdxW)
  ) u_pick (
    .valid_i (valid_i),
    .ptr_i   (rr_q),
    .sel_o   (pick_sel),
    .any_o   (pick_any)
  );

  assign locked    = (state_q == ARB_LOCKED);
  assign cur_idx   = locked ? lock_idx_q : pick_sel;
  assign cur_valid = locked ? valid_i[lock_idx_q] : pick_any;

`ifdef REDUNDANCY_CELLS_ARB_ID_CHECK_EN
  logic [IDSize-1:0] lock_id_q;
  // A different ID on the owner means a new item: hide it and re-arbitrate.
  assign id_mis = locked & valid_i[lock_idx_q] & (id_i[lock_idx_q] != lock_id_q);
`else
  assign id_mis = 1'b0;
`endif

  assign hs     = cur_valid & ~id_mis & ready_i;
  // Watchdog fires only if this cycle brings no handshake.
  assign to_hit = (LockTimeout > 0) && locked && !hs && (tmr_q == TmrLast);

  assign valid_o   = rst_ni & cur_valid & ~id_mis;
  assign data_o    = data_i[cur_idx];
  assign id_o      = id_i[cur_idx];
  assign idx_o     = cur_idx;
  assign locked_o  = rst_ni & locked;
  assign timeout_o = rst_ni & ~flush_i & ~id_mis & to_hit;

  // Ready is only offered to the granted input when a transfer actually occurs,
  // so a stalled owner leaves every input not-ready.
  always_comb begin
    ready_o = '0;
    if (rst_ni && hs) ready_o[cur_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      rr_q       <= '0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
`ifdef REDUNDANCY_CELLS_ARB_ID_CHECK_EN
      lock_id_q  <= '0;
`endif
    end else if (flush_i) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (hs) begin
            if (Redundancy > 1) begin
              state_q    <= ARB_LOCKED;
              lock_idx_q <= cur_idx;
              cnt_q      <= CntW'(1);
              tmr_q      <= '0;
`ifdef REDUNDANCY_CELLS_ARB_ID_CHECK_EN
              lock_id_q  <= id_i[cur_idx];
`endif
            end else begin
              rr_q <= IdxW'(next_idx(32'(cur_idx), NumIn));
            end
          end
        end
        ARB_LOCKED: begin
          if (id_mis) begin
            state_q <= ARB_IDLE;
            rr_q    <= lock_idx_q;
            cnt_q   <= '0;
            tmr_q   <= '0;
          end else if (hs) begin
            tmr_q <= '0;
            if (cnt_q == CntLast) begin
              state_q <= ARB_IDLE;
              rr_q    <= IdxW'(next_idx(32'(lock_idx_q), NumIn));
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (to_hit) begin
            state_q <= ARB_IDLE;
            rr_q    <= IdxW'(next_idx(32'(lock_idx_q), NumIn));
            cnt_q   <= '0;
            tmr_q   <= '0;
          end else if (LockTimeout > 0) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_redundant_lock_arbiter.sv
module tb_time_redundant_lock_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int IW = 5;
  localparam int R  = 3;
  localparam int LT = 5;
`ifdef REDUNDANCY_CELLS_ARB_ID_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n, flush, rdy;
  logic [N-1:0]            vld;
  logic [N-1:0][DW-1:0]    dat;
  logic [N-1:0][IW-1:0]    idv;

  logic [N-1:0] a_ready, b_ready;
  logic         a_valid, b_valid, a_locked, b_locked, a_timeout, b_timeout;
  logic [DW-1:0] a_data, b_data;
  logic [IW-1:0] a_id, b_id;
  logic [1:0]    a_idx, b_idx;

  time_redundant_lock_arbiter #(.NumIn(N), .DataWidth(DW), .IDSize(IW),
    .Redundancy(R), .LockTimeout(LT)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vld), .ready_o(a_ready),
    .data_i(dat), .id_i(idv), .valid_o(a_valid), .ready_i(rdy), .data_o(a_data),
    .id_o(a_id), .idx_o(a_idx), .locked_o(a_locked), .timeout_o(a_timeout));

  time_redundant_lock_arbiter #(.NumIn(N), .DataWidth(DW), .IDSize(IW),
    .Redundancy(1), .LockTimeout(LT)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vld), .ready_o(b_ready),
    .data_i(dat), .id_i(idv), .valid_o(b_valid), .ready_i(rdy), .data_o(b_data),
    .id_o(b_id), .idx_o(b_idx), .locked_o(b_locked), .timeout_o(b_timeout));

  // Reference model: which input owns the current item, its ID, how many
  // copies were delivered and how long the owner has been silent.
  typedef struct {
    bit locked;
    int owner;
    int lid;
    int copies;
    int idle;
    int rr;
  } mst_t;

  typedef struct {
    bit         valid;
    bit [N-1:0] ready;
    int         idx;
    bit         locked;
    bit         timeout;
    bit         hs;
    bit         mis;
  } mout_t;

  mst_t ma, mb;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic mout_t mcomb(mst_t m);
    mout_t o;
    o = '{default: 0};
    if (!rst_n) return o;
    if (m.locked) begin
      o.idx   = m.owner;
      o.mis   = CHK && vld[m.owner] && (int'(idv[m.owner]) != m.lid);
      o.valid = vld[m.owner] && !o.mis;
    end else begin
      o.idx = m.rr;
      for (int k = N - 1; k >= 0; k--)
        if (vld[(m.rr + k) % N]) o.idx = (m.rr + k) % N;
      o.valid = vld[o.idx];
    end
    o.hs = o.valid && rdy;
    if (o.hs) o.ready[o.idx] = 1'b1;
    o.locked  = m.locked;
    o.timeout = m.locked && (LT > 0) && !o.hs && !o.mis && !flush && (m.idle == LT - 1);
    return o;
  endfunction

  function automatic mst_t mnext(mst_t m, int red);
    mout_t o;
    o = mcomb(m);
    if (!rst_n) begin
      m = '{default: 0};
      return m;
    end
    if (flush) begin
      m.locked = 0; m.rr = 0; m.copies = 0; m.idle = 0;
      return m;
    end
    if (m.locked) begin
      if (o.mis) begin
        m.locked = 0; m.rr = m.owner;
      end else if (o.hs) begin
        m.copies++;
        m.idle = 0;
        if (m.copies == red) begin
          m.locked = 0; m.rr = (m.owner + 1) % N;
        end
      end else if (LT > 0 && m.idle == LT - 1) begin
        m.locked = 0; m.rr = (m.owner + 1) % N;
      end else begin
        m.idle++;
      end
    end else if (o.hs) begin
      if (red > 1) begin
        m.locked = 1; m.owner = o.idx; m.lid = int'(idv[o.idx]); m.copies = 1; m.idle = 0;
      end else begin
        m.rr = (o.idx + 1) % N;
      end
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = mnext(ma, R);
    mb = mnext(mb, 1);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; vld = '0; rdy = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; rdy = 1'b1; vld = '1;
    dat = {8'hC3, 8'hB2, 8'hA1}; idv = {5'd17, 5'd9, 5'd4};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if ({a_valid, a_ready, a_locked, a_timeout} !== 6'b0)
        $display("FAIL reset_a: got %b want 000000", {a_valid, a_ready, a_locked, a_timeout});
      else n_pass++;
      n_total++;
      if ({b_valid, b_ready, b_locked, b_timeout} !== 6'b0)
        $display("FAIL reset_b: got %b want 000000", {b_valid, b_ready, b_locked, b_timeout});
      else n_pass++;
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_triplet();
    int exp_idx [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    bit exp_lck [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
    int ids [3] = '{4, 9, 17};
    vld = '1; rdy = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_total++;
      if (a_idx !== 2'(exp_idx[c]) || a_valid !== 1'b1 || a_ready !== 3'(1 << exp_idx[c]))
        $display("FAIL triplet_idx[%0d]: got idx=%0d v=%b r=%b want idx=%0d v=1 r=%b",
                 c, a_idx, a_valid, a_ready, exp_idx[c], 3'(1 << exp_idx[c]));
      else n_pass++;
      n_total++;
      if (a_locked !== exp_lck[c] || a_id !== 5'(ids[exp_idx[c]]))
        $display("FAIL triplet_lock[%0d]: got lock=%b id=%0d want lock=%b id=%0d",
                 c, a_locked, a_id, exp_lck[c], ids[exp_idx[c]]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_lock_hold();
    do_flush();
    rdy = 1'b1; vld = 3'b010;
    tick();
    vld = 3'b101;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if ({a_valid, a_ready, a_locked} !== 5'b0_000_1 || a_idx !== 2'd1)
        $display("FAIL hold_stall[%0d]: got v=%b r=%b l=%b idx=%0d want v=0 r=000 l=1 idx=1",
                 c, a_valid, a_ready, a_locked, a_idx);
      else n_pass++;
      tick();
    end
    vld = 3'b111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if ({a_valid, a_ready} !== 4'b1_010 || a_idx !== 2'd1)
        $display("FAIL hold_resume[%0d]: got v=%b r=%b idx=%0d want v=1 r=010 idx=1",
                 c, a_valid, a_ready, a_idx);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if (a_idx !== 2'd2 || a_locked !== 1'b0)
      $display("FAIL hold_next: got idx=%0d l=%b want idx=2 l=0", a_idx, a_locked);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_flush();
    rdy = 1'b1; vld = 3'b010;
    tick();
    vld = 3'b101;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_total++;
      if (a_timeout !== (c == 5) || a_locked !== 1'b1 || a_valid !== 1'b0)
        $display("FAIL timeout[%0d]: got to=%b l=%b v=%b want to=%b l=1 v=0",
                 c, a_timeout, a_locked, a_valid, (c == 5));
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if (a_idx !== 2'd2 || a_locked !== 1'b0 || a_timeout !== 1'b0)
      $display("FAIL timeout_next: got idx=%0d l=%b to=%b want idx=2 l=0 to=0",
               a_idx, a_locked, a_timeout);
    else n_pass++;
  endtask

  task automatic test_id_mismatch();
    do_flush();
    rdy = 1'b1; vld = 3'b010; idv[1] = 5'd7;
    tick();
    idv[1] = 5'd8;
    @(negedge clk);
    n_total++;
    if (a_valid !== !CHK || a_locked !== 1'b1 || a_id !== 5'd8)
      $display("FAIL idmis_cycle: got v=%b l=%b id=%0d want v=%b l=1 id=8",
               a_valid, a_locked, a_id, !CHK);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (a_locked !== !CHK || a_valid !== 1'b1 || a_idx !== 2'd1)
      $display("FAIL idmis_regrant: got l=%b v=%b idx=%0d want l=%b v=1 idx=1",
               a_locked, a_valid, a_idx, !CHK);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (a_locked !== CHK || a_valid !== 1'b1)
      $display("FAIL idmis_after: got l=%b v=%b want l=%b v=1", a_locked, a_valid, CHK);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    do_flush();
    rdy = 1'b1; vld = 3'b010;
    tick();
    flush = 1'b1;
    @(negedge clk);
    n_total++;
    if ({a_valid, a_ready, a_timeout} !== 5'b1_010_0)
      $display("FAIL flush_hs: got v=%b r=%b to=%b want v=1 r=010 to=0", a_valid, a_ready, a_timeout);
    else n_pass++;
    tick();
    flush = 1'b0; vld = 3'b111;
    @(negedge clk);
    n_total++;
    if (a_locked !== 1'b0 || a_idx !== 2'd0)
      $display("FAIL flush_idle: got l=%b idx=%0d want l=0 idx=0", a_locked, a_idx);
    else n_pass++;
    tick();
  endtask

  task automatic test_rr1();
    int seq [10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
    do_flush();
    rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      vld = (c < 6) ? 3'b111 : 3'b101;
      @(negedge clk);
      n_total++;
      if (b_idx !== 2'(seq[c]) || b_locked !== 1'b0 || b_ready !== 3'(1 << seq[c]))
        $display("FAIL rr1[%0d]: got idx=%0d l=%b r=%b want idx=%0d l=0 r=%b",
                 c, b_idx, b_locked, b_ready, seq[c], 3'(1 << seq[c]));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    mout_t ea, eb;
    logic [IW-1:0] base [N] = '{5'd3, 5'd12, 5'd25};
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 31) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      vld   = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        dat[i] = 8'($urandom);
        idv[i] = ($urandom_range(0, 5) != 0) ? base[i] : 5'($urandom);
      end
      @(negedge clk);
      ea = mcomb(ma);
      eb = mcomb(mb);
      n_total++;
      if ({a_valid, a_ready, a_locked, a_timeout} !== {ea.valid, ea.ready, ea.locked, ea.timeout})
        $display("FAIL rand_a_ctl[%0d]: got %b want %b", c,
                 {a_valid, a_ready, a_locked, a_timeout}, {ea.valid, ea.ready, ea.locked, ea.timeout});
      else n_pass++;
      n_total++;
      if ({b_valid, b_ready, b_locked, b_timeout} !== {eb.valid, eb.ready, eb.locked, eb.timeout})
        $display("FAIL rand_b_ctl[%0d]: got %b want %b", c,
                 {b_valid, b_ready, b_locked, b_timeout}, {eb.valid, eb.ready, eb.locked, eb.timeout});
      else n_pass++;
      if (rst_n) begin
        n_total++;
        if ({a_idx, a_data, a_id} !== {2'(ea.idx), dat[ea.idx], idv[ea.idx]})
          $display("FAIL rand_a_data[%0d]: got idx=%0d d=%h id=%0d want idx=%0d d=%h id=%0d", c,
                   a_idx, a_data, a_id, ea.idx, dat[ea.idx], idv[ea.idx]);
        else n_pass++;
        n_total++;
        if ({b_idx, b_data, b_id} !== {2'(eb.idx), dat[eb.idx], idv[eb.idx]})
          $display("FAIL rand_b_data[%0d]: got idx=%0d d=%h id=%0d want idx=%0d d=%h id=%0d", c,
                   b_idx, b_data, b_id, eb.idx, dat[eb.idx], idv[eb.idx]);
        else n_pass++;
      end
      tick();
    end
    rst_n = 1'b1; flush = 1'b0;
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    test_reset();
    test_triplet();
    test_lock_hold();
    test_timeout();
    test_id_mismatch();
    test_flush();
    test_rr1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
